// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the oversampling command-stream UART receiver.
// Holds the receiver state encoding, sampling constants and the baud divider calculation.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_t;

  localparam int SAMPLE_MID       = 8;
  localparam int OVERSAMPLE_FIXED = 16;

  // Clocks per sample tick, rounded to nearest and never below one.
  function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
    int den;
    int q;
    den = baud * oversample;
    if (den <= 0) begin
      return 1;
    end
    q = (clk_hz + den / 2) / den;
    return (q < 1) ? 1 : q;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_cmd_rx_baud_tick_gen.sv
// Sample-tick generator: one-cycle tick every DIV clocks while enabled.
// Dropping en restarts the count so each frame samples from a clean phase.
module baud_tick_gen #(
  parameter int DIV = 27
) (
  input  logic CLK,
  input  logic CLR,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (CLR || !en) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_cmd_rx.sv
// Oversampling UART receiver feeding the command decoder one framed byte per ByteValid.
// Each bit is judged by a 2-of-3 vote around mid-bit; bad stop bits raise FrameErr instead.
module uart_cmd_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       RxD,
  output logic [7:0] DataOut,
  output logic       ByteValid,
  output logic       FrameErr,
  output logic       Busy
);

  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);

  localparam logic [3:0] SAMP_FIRST  = 4'(SAMPLE_MID - 1);
  localparam logic [3:0] SAMP_SECOND = 4'(SAMPLE_MID);
  localparam logic [3:0] SAMP_DECIDE = 4'(SAMPLE_MID + 1);
  localparam logic [3:0] SAMP_LAST   = 4'(OVERSAMPLE_FIXED - 1);

  generate
    if (OVERSAMPLE != OVERSAMPLE_FIXED) begin : g_bad_oversample
      $error("uart_cmd_rx: OVERSAMPLE must be 16");
    end
  endgenerate

  rx_state_t  state;
  logic       rx_meta;
  logic       rxs;
  logic       tick;
  logic       tick_en;
  logic [3:0] sidx;
  logic [2:0] bitcnt;
  logic [7:0] shreg;
  logic       samp_a;
  logic       samp_b;
  logic       maj;

  // Both flops reset high so a reset never fakes a start edge on its own.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= RxD;
      rxs     <= rx_meta;
    end
  end

  assign tick_en = (state != IDLE);

  baud_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .CLK (CLK),
    .CLR (CLR),
    .en  (tick_en),
    .tick(tick)
  );

  assign maj = majority3(samp_a, samp_b, rxs);

  // Stop-bit verdict is taken at the vote point, so the tail of the stop bit is free for the next start.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state     <= IDLE;
      sidx      <= '0;
      bitcnt    <= '0;
      shreg     <= '0;
      samp_a    <= 1'b0;
      samp_b    <= 1'b0;
      DataOut   <= '0;
      ByteValid <= 1'b0;
      FrameErr  <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      ByteValid <= 1'b0;
      FrameErr  <= 1'b0;

      if (tick) begin
        sidx <= sidx + 4'd1;
        if (sidx == SAMP_FIRST) begin
          samp_a <= rxs;
        end
        if (sidx == SAMP_SECOND) begin
          samp_b <= rxs;
        end
      end

      unique case (state)
        IDLE: begin
          sidx <= '0;
          if (!rxs) begin
            state <= START;
            Busy  <= 1'b1;
          end
        end

        START: begin
          if (tick && sidx == SAMP_DECIDE) begin
            if (maj) begin
              state <= IDLE;
              Busy  <= 1'b0;
              sidx  <= '0;
            end
          end else if (tick && sidx == SAMP_LAST) begin
            state  <= DATA;
            bitcnt <= '0;
          end
        end

        DATA: begin
          if (tick && sidx == SAMP_DECIDE) begin
            shreg <= {maj, shreg[7:1]};
          end else if (tick && sidx == SAMP_LAST) begin
            if (bitcnt == 3'd7) begin
              state <= STOP;
            end else begin
              bitcnt <= bitcnt + 3'd1;
            end
          end
        end

        STOP: begin
          if (tick && sidx == SAMP_DECIDE) begin
            if (maj) begin
              DataOut   <= shreg;
              ByteValid <= 1'b1;
              state     <= IDLE;
              Busy      <= 1'b0;
              sidx      <= '0;
            end else begin
              FrameErr <= 1'b1;
              state    <= WAIT_IDLE;
            end
          end
        end

        WAIT_IDLE: begin
          if (tick && rxs) begin
            state <= IDLE;
            Busy  <= 1'b0;
            sidx  <= '0;
          end
        end

        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
          sidx  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Self-checking bench for uart_cmd_rx at 32 clocks per bit (DIV=2).
// A frame-level model predicts the cycle and value of every ByteValid/FrameErr pulse.
module tb_uart_cmd_rx;

  localparam int BIT_CYC    = 32;
  localparam int DATA_END   = 9 * BIT_CYC;
  localparam int EXIT_TO_EV = (9 * 16 + 10) * 2 + 1;
  localparam int SYNC_LAT   = 2;
  localparam int HIST_LEN   = 65536;

  logic       CLK = 1'b0;
  logic       CLR;
  logic       RxD;
  logic [7:0] DataOut;
  logic       ByteValid;
  logic       FrameErr;
  logic       Busy;

  uart_cmd_rx #(
    .CLK_HZ    (3_200_000),
    .BAUD      (100_000),
    .OVERSAMPLE(16)
  ) dut (
    .CLK      (CLK),
    .CLR      (CLR),
    .RxD      (RxD),
    .DataOut  (DataOut),
    .ByteValid(ByteValid),
    .FrameErr (FrameErr),
    .Busy     (Busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int         checks = 0;
  int         failures = 0;
  int         exp_bv_cyc[$];
  logic [7:0] exp_bv_val[$];
  int         exp_fe_cyc[$];
  logic [7:0] model_data = 8'h00;
  int         prev_idle = 0;
  bit         cmp_on = 1'b0;

  int         bv_count = 0;
  int         fe_count = 0;
  int         last_bv_cyc = 0;
  logic [7:0] last_bv_val = 8'h00;
  logic [7:0] seen[$];
  bit         busy_hist[HIST_LEN];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic v, input int ncyc);
    repeat (ncyc) begin
      RxD = v;
      @(posedge CLK);
      #1;
    end
  endtask

  function automatic logic lineBit(input logic [7:0] val, input bit good, input int off);
    if (off < BIT_CYC) return 1'b0;
    if (off < DATA_END) return val[(off - BIT_CYC) / BIT_CYC];
    return good;
  endfunction

  // A frame is detected once its start edge is synchronized and the receiver is back in idle.
  function automatic void modelFrame(input int n, input logic [7:0] val, input bit good, input int stop_len);
    int d;
    d = (n + SYNC_LAT > prev_idle) ? n + SYNC_LAT : prev_idle;
    if (good) begin
      exp_bv_cyc.push_back(d + EXIT_TO_EV);
      exp_bv_val.push_back(val);
      prev_idle = d + EXIT_TO_EV;
    end else begin
      exp_fe_cyc.push_back(d + EXIT_TO_EV);
      prev_idle = n + DATA_END + stop_len;
    end
  endfunction

  function automatic void modelClear();
    exp_bv_cyc.delete();
    exp_bv_val.delete();
    exp_fe_cyc.delete();
    model_data = 8'h00;
    prev_idle  = cyc;
  endfunction

  task automatic sendFrame(input logic [7:0] val, input bit good, input int stop_len,
                           input int spike_off, input int gap);
    modelFrame(cyc, val, good, stop_len);
    for (int off = 0; off < DATA_END + stop_len; off++) begin
      logic v;
      v = lineBit(val, good, off);
      if (off == spike_off) v = ~v;
      RxD = v;
      @(posedge CLK);
      #1;
    end
    applyStimulus(1'b1, gap);
  endtask

  // Monitor and per-cycle comparison against the frame model.
  always @(negedge CLK) begin : compare
    bit want_bv;
    bit want_fe;
    if (cyc < HIST_LEN) busy_hist[cyc] = Busy;
    if (ByteValid) begin
      bv_count++;
      last_bv_cyc = cyc;
      last_bv_val = DataOut;
      seen.push_back(DataOut);
    end
    if (FrameErr) fe_count++;
    if (cmp_on) begin
      want_bv = 1'b0;
      want_fe = 1'b0;
      if (exp_bv_cyc.size() > 0 && exp_bv_cyc[0] == cyc) begin
        want_bv = 1'b1;
        void'(exp_bv_cyc.pop_front());
        model_data = exp_bv_val.pop_front();
      end
      if (exp_fe_cyc.size() > 0 && exp_fe_cyc[0] == cyc) begin
        want_fe = 1'b1;
        void'(exp_fe_cyc.pop_front());
      end
      checkOutput("ByteValid", 32'(ByteValid), 32'(want_bv));
      checkOutput("FrameErr", 32'(FrameErr), 32'(want_fe));
      checkOutput("DataOut", 32'(DataOut), 32'(model_data));
    end
  end

  initial begin : stim
    int n;
    int bv0;
    int fe0;
    logic [7:0] v;
    bit good;
    int sl;
    int sp;
    int gap;

    CLR = 1'b1;
    RxD = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    CLR = 1'b0;
    checkOutput("reset_DataOut", 32'(DataOut), 32'h00);
    checkOutput("reset_ByteValid", 32'(ByteValid), 0);
    checkOutput("reset_FrameErr", 32'(FrameErr), 0);
    checkOutput("reset_Busy", 32'(Busy), 0);
    prev_idle = cyc;
    cmp_on = 1'b1;
    applyStimulus(1'b1, 10);

    $display("[TB] single byte 0xE3");
    n = cyc; bv0 = bv_count; fe0 = fe_count;
    sendFrame(8'hE3, 1'b1, 32, -1, 40);
    checkOutput("t1_latency", last_bv_cyc - n, 311);
    checkOutput("t1_data", 32'(last_bv_val), 32'hE3);
    checkOutput("t1_bv_count", bv_count - bv0, 1);
    checkOutput("t1_fe_count", fe_count - fe0, 0);

    $display("[TB] back-to-back 0xE5 0x12 0xA5");
    bv0 = bv_count;
    sendFrame(8'hE5, 1'b1, 32, -1, 0);
    sendFrame(8'h12, 1'b1, 32, -1, 0);
    sendFrame(8'hA5, 1'b1, 32, -1, 40);
    checkOutput("t2_bv_count", bv_count - bv0, 3);
    checkOutput("t2_byte0", 32'(seen[seen.size()-3]), 32'hE5);
    checkOutput("t2_byte1", 32'(seen[seen.size()-2]), 32'h12);
    checkOutput("t2_byte2", 32'(seen[seen.size()-1]), 32'hA5);

    $display("[TB] 12-cycle glitch");
    n = cyc; bv0 = bv_count; fe0 = fe_count;
    applyStimulus(1'b0, 12);
    applyStimulus(1'b1, 40);
    checkOutput("t3_busy_before", 32'(busy_hist[n+2]), 0);
    checkOutput("t3_busy_rise", 32'(busy_hist[n+3]), 1);
    checkOutput("t3_busy_last", 32'(busy_hist[n+22]), 1);
    checkOutput("t3_busy_fall", 32'(busy_hist[n+23]), 0);
    checkOutput("t3_bv_count", bv_count - bv0, 0);
    checkOutput("t3_fe_count", fe_count - fe0, 0);

    $display("[TB] low stop bit and break");
    n = cyc; bv0 = bv_count; fe0 = fe_count;
    sendFrame(8'h55, 1'b0, 40 * BIT_CYC, -1, 40);
    checkOutput("t4_fe_count", fe_count - fe0, 1);
    checkOutput("t4_bv_count", bv_count - bv0, 0);
    checkOutput("t4_data_kept", 32'(DataOut), 32'hA5);
    checkOutput("t4_busy_mid", 32'(busy_hist[n+900]), 1);
    checkOutput("t4_busy_end_low", 32'(busy_hist[n+DATA_END+40*BIT_CYC+1]), 1);
    checkOutput("t4_busy_released", 32'(busy_hist[n+DATA_END+40*BIT_CYC+12]), 0);

    $display("[TB] spike on data bit 3");
    sendFrame(8'h00, 1'b1, 32, BIT_CYC + 3 * BIT_CYC + 18, 40);
    checkOutput("t5_data", 32'(last_bv_val), 32'h00);

    $display("[TB] random frames");
    for (int i = 0; i < 20; i++) begin
      v    = 8'($urandom);
      good = ($urandom_range(0, 4) != 0);
      sl   = int'($urandom_range(21, 32));
      sp   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(BIT_CYC, DATA_END - 1)) : -1;
      gap  = good ? int'($urandom_range(0, 20)) : int'($urandom_range(12, 40));
      sendFrame(v, good, sl, sp, gap);
    end
    applyStimulus(1'b1, 40);

    $display("[TB] reset mid-frame");
    sendFrame(8'hC3, 1'b1, 32, -1, 40);
    for (int off = 0; off < BIT_CYC + 4 * BIT_CYC + 10; off++) begin
      RxD = lineBit(8'h96, 1'b1, off);
      @(posedge CLK);
      #1;
    end
    checkOutput("t6_busy_before", 32'(Busy), 1);
    RxD = 1'b1;
    CLR = 1'b1;
    @(posedge CLK);
    #1;
    CLR = 1'b0;
    modelClear();
    checkOutput("t6_DataOut", 32'(DataOut), 32'h00);
    checkOutput("t6_ByteValid", 32'(ByteValid), 0);
    checkOutput("t6_FrameErr", 32'(FrameErr), 0);
    checkOutput("t6_Busy", 32'(Busy), 0);
    bv0 = bv_count;
    applyStimulus(1'b1, 40);
    sendFrame(8'h3C, 1'b1, 32, -1, 40);
    checkOutput("t6_bv_count", bv_count - bv0, 1);
    checkOutput("t6_data", 32'(last_bv_val), 32'h3C);

    checkOutput("pending_events", exp_bv_cyc.size() + exp_fe_cyc.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
